// File: rtl/acq_pkg.sv
// ============================================================================
//  Module      : acq_pkg
//  Description : Shared definitions for the acquisition frame sequencer.
//                It holds the state encoding and the function that sizes the
//                sample index.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package acq_pkg;

  // State encoding, fixed so that it stays stable across tools and revisions.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_TX      = 3'd1;
  localparam logic [2:0] ST_GUARD   = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_TX      = ST_TX,
    S_GUARD   = ST_GUARD,
    S_CAPTURE = ST_CAPTURE,
    S_DONE    = ST_DONE
  } state_t;

  // Number of bits needed to index n samples. The result is never narrower
  // than 1 bit, so that the port stays legal.
  function automatic int sample_idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/acq_sequencer_strobe_divider.sv
// ============================================================================
//  Module      : strobe_divider
//  Description : Issues a 1-cycle pulse on the first enabled cycle, then one
//                pulse every SAMPLE_DIV enabled cycles. i_clear restarts the
//                phase, so the next enabled cycle pulses again.
//  Ports       : clk_in, rstn     clock and async active-low reset
//                i_clear          restart phase (takes priority over i_en)
//                i_en             advance the divider this cycle
//                o_pulse          registered pulse; it is high in the cycle
//                                 after the enabled cycle that fired
//                o_pulse_next     combinational: o_pulse will be high next
//                                 cycle
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module strobe_divider #(
  parameter int SAMPLE_DIV = 100
) (
  input  logic clk_in,
  input  logic rstn,
  input  logic i_clear,
  input  logic i_en,
  output logic o_pulse,
  output logic o_pulse_next
);

  localparam int              CW     = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0]   c_last = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_pulse;

  // The phase counter sits at 0 exactly on the cycles that must fire.
  assign o_pulse_next = i_en && !i_clear && (r_cnt == '0);
  assign o_pulse      = r_pulse;

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= o_pulse_next;
      if (i_clear) begin
        r_cnt <= '0;
      end else if (i_en) begin
        r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + CW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/acq_sequencer.sv
// ============================================================================
//  Module      : acq_sequencer
//  Description : Ranging frame sequencer. Each accepted trigger runs the
//                sequence TX burst -> guard gap -> capture window (with
//                sample strobes and an index) -> one-cycle DONE. The block
//                counts completed frames and flags triggers that it misses.
//  Ports       : clk_in, rstn      clock and async active-low reset
//                trigger_in        1-cycle frame-start pulse
//                enable            level; low aborts a frame or holds in idle
//                clear_overrun     1-cycle pulse that clears overrun
//                tx_en             transmit burst enable
//                capture_en        capture window active
//                sample_strobe     1-cycle "take a sample" pulse
//                sample_idx        index of the current sample
//                frame_done        1-cycle pulse when a frame completes
//                frame_count       completed frames; wraps around
//                busy              high whenever a frame is in progress
//                overrun           sticky flag for a missed trigger
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module acq_sequencer
  import acq_pkg::*;
#(
  parameter int TX_CYCLES       = 1000,
  parameter int GUARD_CYCLES    = 2000,
  parameter int CAPTURE_SAMPLES = 4096,
  parameter int SAMPLE_DIV      = 100,
  parameter int CNT_W           = 20,
  parameter int FRAME_W         = 16
) (
  input  logic                                     clk_in,
  input  logic                                     rstn,
  input  logic                                     trigger_in,
  input  logic                                     enable,
  input  logic                                     clear_overrun,
  output logic                                     tx_en,
  output logic                                     capture_en,
  output logic                                     sample_strobe,
  output logic [sample_idx_w(CAPTURE_SAMPLES)-1:0] sample_idx,
  output logic                                     frame_done,
  output logic [FRAME_W-1:0]                       frame_count,
  output logic                                     busy,
  output logic                                     overrun
);

  localparam int     IDX_W       = sample_idx_w(CAPTURE_SAMPLES);
  localparam longint CAPTURE_LEN = longint'(CAPTURE_SAMPLES) * longint'(SAMPLE_DIV);
  localparam longint CNT_SPAN    = longint'(1) << CNT_W;

  // Each phase counter counts down from its (length-1) to 0.
  localparam logic [CNT_W-1:0] c_tx_load    = CNT_W'(TX_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_guard_load = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cap_load   = CNT_W'(CAPTURE_LEN - 1);

  // Reject parameter sets where a phase does not fit the counter or is
  // shorter than its minimum.
  generate
    if (TX_CYCLES < 1 || GUARD_CYCLES < 1 || CAPTURE_SAMPLES < 2 || SAMPLE_DIV < 1 ||
        longint'(TX_CYCLES) > CNT_SPAN || longint'(GUARD_CYCLES) > CNT_SPAN ||
        CAPTURE_LEN > CNT_SPAN) begin : g_bad_params
      $error("acq_sequencer: illegal parameter set for CNT_W=%0d", CNT_W);
    end
  endgenerate

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_tx_en;
  logic               r_cap_en;
  logic               r_done;
  logic               r_busy;
  logic               r_ov;
  logic [IDX_W-1:0]   r_idx;
  logic [FRAME_W-1:0] r_fc;

  logic w_cap_next;
  logic w_strobe;
  logic w_strobe_next;

  // The next cycle is a capture cycle in two cases: the guard phase is
  // ending, or capture continues. The divider runs one cycle ahead so that
  // its registered pulse lines up with capture_en.
  assign w_cap_next = enable &&
                      (((r_state == S_GUARD)   && (r_cnt == '0)) ||
                       ((r_state == S_CAPTURE) && (r_cnt != '0)));

  strobe_divider #(
    .SAMPLE_DIV (SAMPLE_DIV)
  ) u_strobe_div (
    .clk_in       (clk_in),
    .rstn         (rstn),
    .i_clear      (!w_cap_next),
    .i_en         (w_cap_next),
    .o_pulse      (w_strobe),
    .o_pulse_next (w_strobe_next)
  );

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_tx_en  <= 1'b0;
      r_cap_en <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_ov     <= 1'b0;
      r_idx    <= '0;
      r_fc     <= '0;
    end else begin
      // A new miss takes priority over a clear in the same cycle.
      if (trigger_in && enable && (r_state != S_IDLE)) begin
        r_ov <= 1'b1;
      end else if (clear_overrun) begin
        r_ov <= 1'b0;
      end

      r_done <= 1'b0;

      if ((r_state != S_IDLE) && !enable) begin
        // Abort: drop to idle without completing the frame.
        r_state  <= S_IDLE;
        r_cnt    <= '0;
        r_tx_en  <= 1'b0;
        r_cap_en <= 1'b0;
        r_busy   <= 1'b0;
        r_idx    <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (trigger_in && enable) begin
              r_state <= S_TX;
              r_cnt   <= c_tx_load;
              r_tx_en <= 1'b1;
              r_busy  <= 1'b1;
            end
          end
          S_TX: begin
            if (r_cnt == '0) begin
              r_state <= S_GUARD;
              r_cnt   <= c_guard_load;
              r_tx_en <= 1'b0;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          S_GUARD: begin
            if (r_cnt == '0) begin
              r_state  <= S_CAPTURE;
              r_cnt    <= c_cap_load;
              r_cap_en <= 1'b1;
              r_idx    <= '0;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          S_CAPTURE: begin
            if (r_cnt == '0) begin
              r_state  <= S_DONE;
              r_cap_en <= 1'b0;
              r_done   <= 1'b1;
              r_fc     <= r_fc + FRAME_W'(1);
              r_idx    <= '0;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
              // The index advances together with every strobe after the first.
              if (w_strobe_next) begin
                r_idx <= r_idx + IDX_W'(1);
              end
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_tx_en  <= 1'b0;
            r_cap_en <= 1'b0;
            r_busy   <= 1'b0;
            r_idx    <= '0;
          end
        endcase
      end
    end
  end

  assign tx_en         = r_tx_en;
  assign capture_en    = r_cap_en;
  assign sample_strobe = w_strobe;
  assign sample_idx    = r_idx;
  assign frame_done    = r_done;
  assign frame_count   = r_fc;
  assign busy          = r_busy;
  assign overrun       = r_ov;

endmodule

`default_nettype wire

// File: tb/tb_acq_sequencer.sv
// ============================================================================
//  Module      : tb_acq_sequencer
//  Description : Testbench for acq_sequencer. Two instances share the same
//                inputs: one with SAMPLE_DIV=2 and one with SAMPLE_DIV=1.
//                Both use FRAME_W=2. Every cycle, a frame-timeline model
//                predicts all of the outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_acq_sequencer;

  localparam int TX = 4;
  localparam int G  = 3;
  localparam int S  = 5;

  logic clk_in = 1'b0;
  logic rstn = 1'b0;
  logic trigger_in = 1'b0;
  logic enable = 1'b0;
  logic clear_overrun = 1'b0;

  logic       a_tx, a_cap, a_st, a_done, a_busy, a_ov;
  logic [2:0] a_idx;
  logic [1:0] a_fc;
  logic       b_tx, b_cap, b_st, b_done, b_busy, b_ov;
  logic [2:0] b_idx;
  logic [1:0] b_fc;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model state for each instance: whether a frame is in progress, and the
  // cycle number within that frame (1 = first TX cycle).
  int m_act [2];
  int m_d   [2];
  int m_fc  [2];
  int m_ov  [2];

  always #5 clk_in = ~clk_in;

  acq_sequencer #(
    .TX_CYCLES(TX), .GUARD_CYCLES(G), .CAPTURE_SAMPLES(S), .SAMPLE_DIV(2),
    .CNT_W(8), .FRAME_W(2)
  ) u_dut (
    .clk_in(clk_in), .rstn(rstn), .trigger_in(trigger_in), .enable(enable),
    .clear_overrun(clear_overrun), .tx_en(a_tx), .capture_en(a_cap),
    .sample_strobe(a_st), .sample_idx(a_idx), .frame_done(a_done),
    .frame_count(a_fc), .busy(a_busy), .overrun(a_ov)
  );

  acq_sequencer #(
    .TX_CYCLES(TX), .GUARD_CYCLES(G), .CAPTURE_SAMPLES(S), .SAMPLE_DIV(1),
    .CNT_W(8), .FRAME_W(2)
  ) u_div1 (
    .clk_in(clk_in), .rstn(rstn), .trigger_in(trigger_in), .enable(enable),
    .clear_overrun(clear_overrun), .tx_en(b_tx), .capture_en(b_cap),
    .sample_strobe(b_st), .sample_idx(b_idx), .frame_done(b_done),
    .frame_count(b_fc), .busy(b_busy), .overrun(b_ov)
  );

  function automatic int divof(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int cap0();
    return TX + G + 1;
  endfunction

  function automatic int flen(input int i);
    return cap0() + S * divof(i);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_d[i] = 0; m_fc[i] = 0; m_ov[i] = 0;
    end
  endtask

  // Advance the model by one clock edge, using the inputs seen at that edge.
  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      if (trigger_in && enable && m_act[i] != 0) m_ov[i] = 1;
      else if (clear_overrun) m_ov[i] = 0;
      if (m_act[i] != 0) begin
        if (!enable || m_d[i] == flen(i)) begin
          m_act[i] = 0;
          m_d[i]   = 0;
        end else begin
          m_d[i] = m_d[i] + 1;
          if (m_d[i] == flen(i)) m_fc[i] = (m_fc[i] + 1) % 4;
        end
      end else if (trigger_in && enable) begin
        m_act[i] = 1;
        m_d[i]   = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      int dv, d, c0, fl;
      logic a, e_tx, e_cap, e_st, e_done;
      int e_idx;
      dv = divof(i); d = m_d[i]; c0 = cap0(); fl = flen(i);
      a      = (m_act[i] != 0);
      e_tx   = a && d <= TX;
      e_cap  = a && d >= c0 && d < fl;
      e_st   = e_cap && ((d - c0) % dv == 0);
      e_idx  = e_cap ? (d - c0) / dv : 0;
      e_done = a && d == fl;
      chk($sformatf("u%0d.tx_en", i),         32'(i == 0 ? a_tx   : b_tx),   32'(e_tx));
      chk($sformatf("u%0d.capture_en", i),    32'(i == 0 ? a_cap  : b_cap),  32'(e_cap));
      chk($sformatf("u%0d.sample_strobe", i), 32'(i == 0 ? a_st   : b_st),   32'(e_st));
      chk($sformatf("u%0d.sample_idx", i),    32'(i == 0 ? a_idx  : b_idx),  32'(e_idx));
      chk($sformatf("u%0d.frame_done", i),    32'(i == 0 ? a_done : b_done), 32'(e_done));
      chk($sformatf("u%0d.frame_count", i),   32'(i == 0 ? a_fc   : b_fc),   32'(m_fc[i]));
      chk($sformatf("u%0d.busy", i),          32'(i == 0 ? a_busy : b_busy), 32'(a));
      chk($sformatf("u%0d.overrun", i),       32'(i == 0 ? a_ov   : b_ov),   32'(m_ov[i]));
    end
  endtask

  // One clock cycle: apply the inputs, take the edge, update the model,
  // then check the outputs 1 ns after the edge.
  task automatic step(input logic trg, input logic clr);
    trigger_in    = trg;
    clear_overrun = clr;
    @(posedge clk_in);
    model_update();
    #1;
    check_all();
    trigger_in    = 1'b0;
    clear_overrun = 1'b0;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0);
  endtask

  task automatic run_to_d(input int target);
    int k;
    k = 0;
    while (!(m_act[0] != 0 && m_d[0] == target) && k < 200) begin
      step(1'b0, 1'b0);
      k++;
    end
    chk("reach_phase", 32'(m_d[0]), 32'(target));
  endtask

  task automatic async_reset();
    #3 rstn = 1'b0;
    #1;
    model_reset();
    check_all();
    #2 rstn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    // Reset state
    #2;
    check_all();
    @(posedge clk_in);
    #1 check_all();
    #2 rstn = 1'b1;
    enable = 1'b1;
    cyc = 0;

    // Nominal frame with trigger at cycle 10; second trigger at cycle 20 is an overrun
    idle(10);
    step(1'b1, 1'b0);                     // cycle 10
    idle(9);                              // cycles 11..19
    step(1'b1, 1'b0);                     // cycle 20
    idle(19);                             // cycles 21..39
    step(1'b0, 1'b1);                     // cycle 40: clear
    idle(3);

    // Set and clear in the same cycle: overrun stays set
    step(1'b1, 1'b0);
    idle(2);
    step(1'b1, 1'b1);
    run_to_d(flen(0));
    idle(2);
    step(1'b0, 1'b1);
    idle(2);

    // Abort mid-capture (trigger coincident with abort is ignored), then a clean frame
    step(1'b1, 1'b0);
    run_to_d(cap0() + 1);
    enable = 1'b0;
    step(1'b1, 1'b0);
    enable = 1'b1;
    idle(2);
    step(1'b1, 1'b0);
    run_to_d(flen(0));
    idle(2);

    // Back-to-back: trigger in DONE is missed, next IDLE trigger accepted
    step(1'b1, 1'b0);
    run_to_d(flen(0));
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    run_to_d(flen(0));
    idle(2);
    step(1'b0, 1'b1);

    // Several complete frames so the 2-bit frame counter wraps
    for (int f = 0; f < 5; f++) begin
      step(1'b1, 1'b0);
      run_to_d(flen(0));
      idle(1);
    end

    // Async reset mid-capture
    step(1'b1, 1'b0);
    run_to_d(cap0() + 3);
    async_reset();
    idle(3);

    // Randomized traffic
    for (int n = 0; n < 2500; n++) begin
      enable = ($urandom_range(0, 99) < 97);
      step(1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 19) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
